// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo event counter.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/vin_edge_sync.sv
// Synchronises the asynchronous vin into clk and flags each rising edge for one cycle.
module vin_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic vin,
  output logic vin_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   vin_d_q, vin_d_d;
  logic                   vin_s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], vin};
    vin_s   = sync_q[SYNC_STAGES-1];
    vin_d_d = vin_s;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync_q  <= '0;
      vin_d_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vin_d_q <= vin_d_d;
    end
  end

  // Decoded from flops only, so the consumer sees a clean one-cycle strobe.
  assign vin_rise = vin_s & ~vin_d_q;

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with load, wrap/saturate, terminal-count pulse, sticky
// overflow, and a vin-edge-triggered vout flag, all on one clock.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_VAL     = (2 ** WIDTH) - 1,
  parameter mode_e       MODE        = MODE_WRAP,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             stop,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             vin,
  output logic [WIDTH-1:0] dataout,
  output logic             tc,
  output logic             ovf,
  output logic             vout
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             vout_q, vout_d;
  logic             vin_rise;

  vin_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_vin_sync (
    .clk     (clk),
    .res     (res),
    .vin     (vin),
    .vin_rise(vin_rise)
  );

  // Next-state: load beats stop beats enable; terminal steps pulse tc and set ovf.
  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    ovf_d  = ovf_q;
    vout_d = vout_q;

    if (load) begin
      cnt_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (!stop && en) begin
      if (dir == DIR_UP) begin
        if (cnt_q == MAX_C) begin
          cnt_d = (MODE == MODE_WRAP) ? '0 : MAX_C;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = (MODE == MODE_WRAP) ? MAX_C : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end

    if (vin_rise) begin
      vout_d = ~stop;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      vout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      vout_q <= vout_d;
    end
  end

  assign dataout = cnt_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign vout    = vout_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench: a WRAP and a SAT instance share stimulus; results checked against hand values.
module tb_mod_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       res, en, stop, dir, load, vin;
  logic [7:0] load_val;
  logic [7:0] w_dout, s_dout;
  logic       w_tc, w_ovf, w_vout, s_tc, s_ovf, s_vout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .MAX_VAL(9), .MODE(MODE_WRAP), .SYNC_STAGES(2)) u_wrap (
    .clk(clk), .res(res), .en(en), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .vin(vin),
    .dataout(w_dout), .tc(w_tc), .ovf(w_ovf), .vout(w_vout)
  );

  mod_counter #(.WIDTH(8), .MAX_VAL(9), .MODE(MODE_SAT), .SYNC_STAGES(2)) u_sat (
    .clk(clk), .res(res), .en(en), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .vin(vin),
    .dataout(s_dout), .tc(s_tc), .ovf(s_ovf), .vout(s_vout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input int d, input bit t, input bit o);
    chk({tag, ".w_dout"}, 32'(w_dout), 32'(d));
    chk({tag, ".w_tc"},   32'(w_tc),   32'(t));
    chk({tag, ".w_ovf"},  32'(w_ovf),  32'(o));
  endtask

  task automatic check_s(input string tag, input int d, input bit t, input bit o);
    chk({tag, ".s_dout"}, 32'(s_dout), 32'(d));
    chk({tag, ".s_tc"},   32'(s_tc),   32'(t));
    chk({tag, ".s_ovf"},  32'(s_ovf),  32'(o));
  endtask

  task automatic check_vout(input string tag, input bit v);
    chk({tag, ".w_vout"}, 32'(w_vout), 32'(v));
    chk({tag, ".s_vout"}, 32'(s_vout), 32'(v));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b1; en = 1'b0; stop = 1'b0; dir = DIR_UP; load = 1'b0; load_val = 8'd0; vin = 1'b0;
    step();
    check_w("reset", 0, 1'b0, 1'b0);
    check_s("reset", 0, 1'b0, 1'b0);
    check_vout("reset", 1'b0);

    // Count up 12 cycles: WRAP runs 1..9,0,1,2; SAT pins at 9 and keeps pulsing tc.
    res = 1'b0; en = 1'b1; dir = DIR_UP;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_w($sformatf("up%0d", k), k % 10, k == 10, k >= 10);
      check_s($sformatf("up%0d", k), (k <= 9) ? k : 9, k >= 10, k >= 10);
    end

    // Reset, load 2, then count down 5 cycles.
    res = 1'b1; en = 1'b0;
    step();
    res = 1'b0; load = 1'b1; load_val = 8'd2;
    step();
    check_w("ld2", 2, 1'b0, 1'b0);
    check_s("ld2", 2, 1'b0, 1'b0);
    load = 1'b0; dir = DIR_DOWN; en = 1'b1;
    step(); check_w("dn1", 1, 1'b0, 1'b0); check_s("dn1", 1, 1'b0, 1'b0);
    step(); check_w("dn2", 0, 1'b0, 1'b0); check_s("dn2", 0, 1'b0, 1'b0);
    step(); check_w("dn3", 9, 1'b1, 1'b1); check_s("dn3", 0, 1'b1, 1'b1);
    step(); check_w("dn4", 8, 1'b0, 1'b1); check_s("dn4", 0, 1'b1, 1'b1);
    step(); check_w("dn5", 7, 1'b0, 1'b1); check_s("dn5", 0, 1'b1, 1'b1);

    // Load clamps to MAX_VAL and acts despite stop; load beats a terminal step.
    res = 1'b1; en = 1'b0;
    step();
    res = 1'b0; load = 1'b1; stop = 1'b1; load_val = 8'd200;
    step();
    check_w("clamp", 9, 1'b0, 1'b0);
    check_s("clamp", 9, 1'b0, 1'b0);
    stop = 1'b0; en = 1'b1; dir = DIR_UP; load = 1'b1; load_val = 8'd3;
    step();
    check_w("ld_vs_tc", 3, 1'b0, 1'b0);
    check_s("ld_vs_tc", 3, 1'b0, 1'b0);

    // Stop freeze at 5, resume to 6.
    load = 1'b1; load_val = 8'd4; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check_w("run5", 5, 1'b0, 1'b0);
    stop = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_w($sformatf("stop%0d", k), 5, 1'b0, 1'b0);
    end
    stop = 1'b0;
    step();
    check_w("resume", 6, 1'b0, 1'b0);

    // vin edge with stop=0 sets vout two edges after first capture.
    en = 1'b0; vin = 1'b1;
    step(); check_vout("vin_a1", 1'b0);
    step(); check_vout("vin_a2", 1'b0);
    step(); check_vout("vin_a3", 1'b1);
    step(); check_vout("vin_a4", 1'b1);
    vin = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_vout($sformatf("hold%0d", k), 1'b1);
    end
    stop = 1'b1; vin = 1'b1;
    step(); check_vout("vin_b1", 1'b1);
    step(); check_vout("vin_b2", 1'b1);
    step(); check_vout("vin_b3", 1'b0);
    step(); check_vout("vin_b4", 1'b0);

    // Build dataout=7, ovf=1, vout=1, then reset with a vin edge in flight.
    stop = 1'b0; vin = 1'b0; load = 1'b1; load_val = 8'd9;
    step();
    load = 1'b0; en = 1'b1; dir = DIR_UP;
    step();
    check_w("pre_wrap", 0, 1'b1, 1'b1);
    load = 1'b1; load_val = 8'd7; en = 1'b0;
    step();
    load = 1'b0;
    step(); step(); step();
    vin = 1'b1;
    step(); step(); step();
    check_vout("pre_v", 1'b1);
    check_w("pre_rst", 7, 1'b0, 1'b1);
    vin = 1'b0;
    step(); step(); step();
    vin = 1'b1;
    step();
    res = 1'b1; vin = 1'b0;
    step();
    check_w("midrst", 0, 1'b0, 1'b0);
    check_vout("midrst", 1'b0);
    res = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_vout($sformatf("post_rst%0d", k), 1'b0);
    end
    check_w("post_rst", 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised successor to the team's free-running 8-bit counter and its `vin`-triggered `vout` flag. It adds the following:
- configurable width and modulus
- up/down counting with load and enable
- wrap or saturate mode, with a terminal-count pulse and a sticky overflow flag
- `vin` synchronised into the `clk` domain, so all state changes on one clock

It sits in the timing/event-counting datapath in the same place as the original counter.

## Interface
- `WIDTH`, default 8: counter width in bits.
- `MAX_VAL`, default 2**WIDTH-1: terminal value; count range is 0..MAX_VAL; must be ≥1 and ≤ 2**WIDTH-1.
- `MODE`, default MODE_WRAP: MODE_WRAP (modulo MAX_VAL+1) or MODE_SAT (hold at limit).
- `SYNC_STAGES`, default 2: synchroniser depth for `vin`, ≥2.
- `clk`  in  1: single clock, all logic on rising edge.
- `res`  in  1: reset, synchronous and active-high.
- `en`  in  1: count enable.
- `stop`  in  1: freezes the counter; also selects the `vout` value on a `vin` edge.
- `dir`  in  1: 1 = up, 0 = down.
- `load`  in  1: load `load_val` into counter.
- `load_val`  in  WIDTH: load value.
- `vin`  in  1: asynchronous event input.
- `dataout`  out  WIDTH: current count.
- `tc`  out  1: one-cycle terminal-count pulse.
- `ovf`  out  1: sticky wrap/saturation flag.
- `vout`  out  1: event flag, updated on each synchronised `vin` rising edge.

## Operation
- Reset (`res`=1 at a clk edge) sets:
  - `dataout`=0, `tc`=0, `ovf`=0, `vout`=0
  - all synchroniser and edge-detect flops = 0

  `res` overrides every other input, including mid-count and mid-synchronisation.
- Counter priority per edge, highest first: `res` > `load` > `stop` > `en`.
- `load`=1: `dataout` ← min(`load_val`, MAX_VAL); `tc`←0; `ovf` unchanged. `load` acts even when `stop`=1.
- `stop`=1 (no load): `dataout` holds and `tc`←0.
- `en`=0: `dataout` holds and `tc`←0.
- Step (`en`=1, `stop`=0, `load`=0):
  - Up, `dataout`<MAX_VAL: +1.
  - Up, `dataout`==MAX_VAL: WRAP → 0; SAT → hold at MAX_VAL. In both modes `tc`←1 and `ovf`←1.
  - Down, `dataout`>0: −1.
  - Down, `dataout`==0: WRAP → MAX_VAL; SAT → hold at 0. In both modes `tc`←1 and `ovf`←1.
  - Any other step: `tc`←0.
- Arithmetic is unsigned at WIDTH bits. With MAX_VAL < 2**WIDTH−1, values above MAX_VAL are unreachable.
- `ovf` clears only on `res`.
- `vin` path:
  - `vin` passes through SYNC_STAGES flops to give `vin_s`, then one more flop to give `vin_d`.
  - An edge is detected when `vin_s`=1 and `vin_d`=0.
  - On a detected edge, `vout` ← ~`stop`, with `stop` sampled at that clk edge.
  - Otherwise `vout` holds.
- The `vin` path is independent of `en`, `load` and `dir`.

## Timing
- All outputs are registered; there is no combinational input→output path.
- `dataout` and `tc` reflect a step one clk after the enabling edge. `tc` is high for exactly one cycle per terminal step.
- Counting continuously at the terminal value: each step re-pulses `tc`. In SAT mode this means `tc` stays high while the counter is pinned and enabled.
- `vin` rising, first sampled high at edge N: `vout` updates at edge N+SYNC_STAGES. With the default of 2, that is 2 cycles after first capture.
- `vin` pulses shorter than one clk period may be missed. `vin` edges must be ≥ SYNC_STAGES+1 clk apart to be counted individually.
- `dir` change takes effect on the next step with no extra latency.
- `load` and a terminal step in the same cycle: `load` wins, and `tc`/`ovf` are not set.

## Structure
- Package `counter_pkg`: `mode_e` enum {MODE_WRAP, MODE_SAT}, and constants DIR_UP=1, DIR_DOWN=0.
- Sub-module `vin_edge_sync` (parameter SYNC_STAGES) holds the synchroniser chain and rising-edge detector and outputs a one-cycle `vin_rise`.
- `mod_counter` holds the counter, `tc`/`ovf` logic and the `vout` register.

## Test plan
Unless stated otherwise, WIDTH=8, MAX_VAL=9, SYNC_STAGES=2.
- MODE_WRAP, counting up:
  - Stimulus: `res` 1 cycle, then `en`=1, `dir`=1 for 12 cycles.
  - Response: `dataout` runs 1..9, 0, 1, 2; `tc` pulses once, in the cycle `dataout`=0; `ovf`=1 afterwards.
- MODE_SAT, counting down:
  - Stimulus: `load`=1 with `load_val`=2, then `dir`=0, `en`=1 for 5 cycles.
  - Response: `dataout` = 1, 0, 0, 0, 0; `tc` high on the three hold cycles; `ovf`=1.
- Load clamp and priority:
  - Stimulus: `load_val`=200 with `load`=1 and `stop`=1.
  - Response: `dataout`=9.
  - Then with `dataout`=9, `en`=1, `dir`=1 and `load`=1 (`load_val`=3) in the same cycle: `dataout`=3, `tc`=0, `ovf` unchanged.
- `stop` freeze:
  - Stimulus: while counting at 5, `stop`=1 for 3 cycles.
  - Response: `dataout` holds at 5; `tc`=0; counting resumes at 6 after release.
- `vin` edge:
  - Stimulus: `stop`=0 and `vin` rises, held 4 cycles; later `stop`=1 and `vin` rises again.
  - Response: `vout`=1 exactly 2 edges after first capture, then 0 after the second edge; `vout` holds between edges.
- Reset mid-operation:
  - Stimulus: `res` asserted while `dataout`=7, `ovf`=1, `vout`=1, with a `vin` edge in flight.
  - Response: all outputs 0 next cycle; the in-flight `vin` edge does not produce a `vout` change.
